// File: rtl/sel_bank_pkg.sv
// ---------------------------------------------------------------------------
// sel_bank_pkg
// Shared types and helpers for the sel_bank_pipe block.
//   mode_e       : word transform applied on push (PASS/INVERT/PARITY/HOLD)
//   fifo_state_e : occupancy of the 2-entry skid FIFO (EMPTY/ONE/TWO)
//   par_of()     : even parity (XOR reduce) of a word
// ---------------------------------------------------------------------------
package sel_bank_pkg;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    INVERT = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifo_state_e;

  // Callers zero-extend their word to this width; zero padding does not
  // change the XOR reduction, so one function serves every WIDTH up to here.
  localparam int PAR_MAX_W = 1024;

  function automatic logic par_of(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/sel_bank_pipe_lane_mux.sv
// ---------------------------------------------------------------------------
// sel_bank_lane_mux
// Combinational lane select, select range check and mode transform.
// Ports:
//   i_data    : LANES packed words, lane k at [k*WIDTH +: WIDTH]
//   i_sel     : lane select
//   i_mode    : transform to apply
//   i_hold    : stored value returned by HOLD mode
//   o_word    : transformed word
//   o_sel_err : i_sel addresses a lane that does not exist
// ---------------------------------------------------------------------------
module sel_bank_lane_mux
  import sel_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int SEL_W = 2
) (
  input  logic [LANES*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]       i_sel,
  input  mode_e                  i_mode,
  input  logic [WIDTH-1:0]       i_hold,
  output logic [WIDTH-1:0]       o_word,
  output logic                   o_sel_err
);

  logic [WIDTH-1:0] w_lane;

  // An out-of-range select matches no lane and therefore yields zero.
  always_comb begin
    w_lane = '0;
    for (int k = 0; k < LANES; k++) begin
      if (i_sel == SEL_W'(k)) begin
        w_lane = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Compared at integer width so non-power-of-two LANES is caught correctly.
  assign o_sel_err = (int'(i_sel) >= LANES);

  always_comb begin
    o_word = w_lane;
    case (i_mode)
      PASS:    o_word = w_lane;
      INVERT:  o_word = ~w_lane;
      PARITY: begin
        o_word    = '0;
        o_word[0] = par_of(PAR_MAX_W'(w_lane));
      end
      HOLD:    o_word = i_hold;
      default: o_word = w_lane;
    endcase
  end

endmodule

// File: rtl/sel_bank_pipe.sv
// ---------------------------------------------------------------------------
// sel_bank_pipe
// Registered lane selector: picks one of LANES words, transforms it by mode
// and buffers the result in a 2-entry skid FIFO with valid/ready on both
// sides. Also keeps a wrapping output transfer counter and a sticky
// select-error flag.
// Ports:
//   clock, reset_n       : rising-edge clock, async active-low reset
//   in_valid / in_ready  : upstream handshake (in_ready is registered)
//   in_data, in_sel      : packed lanes and lane select
//   in_mode              : 0 PASS, 1 INVERT, 2 PARITY, 3 HOLD
//   out_valid/out_ready  : downstream handshake
//   out_data, out_par    : FIFO head and its even parity
//   out_count            : completed output transfers, wrapping
//   sel_err              : sticky, an accepted word had in_sel >= LANES
//
// state | meaning
// EMPTY | no word buffered, head invalid
// ONE   | head register holds the oldest word
// TWO   | head and skid both full, upstream stalled
// ---------------------------------------------------------------------------
module sel_bank_pipe
  import sel_bank_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int LANES = 4,
  parameter  int CNT_W = 8,
  localparam int SEL_W = $clog2(LANES)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_par,
  output logic [CNT_W-1:0]       out_count,
  output logic                   sel_err
);

  fifo_state_e      r_state;
  fifo_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_head_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_count;
  logic             r_sel_err;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_word;
  logic             w_oor;
  mode_e            w_mode;

  assign w_mode = mode_e'(in_mode);
  assign w_push = in_valid & r_in_ready;
  assign w_pop  = (r_state != EMPTY) & out_ready;

  sel_bank_lane_mux #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .SEL_W (SEL_W)
  ) u_lane_mux (
    .i_data    (in_data),
    .i_sel     (in_sel),
    .i_mode    (w_mode),
    .i_hold    (r_hold),
    .o_word    (w_word),
    .o_sel_err (w_oor)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;
    case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_state_nxt = ONE;
          w_head_nxt  = w_word;
        end
      end
      ONE: begin
        if (w_push && !w_pop) begin
          w_state_nxt = TWO;
          w_skid_nxt  = w_word;
        end else if (!w_push && w_pop) begin
          w_state_nxt = EMPTY;
        end else if (w_push && w_pop) begin
          w_head_nxt  = w_word;
        end
      end
      TWO: begin
        // in_ready is low here, so only a pop can happen.
        if (w_pop) begin
          w_state_nxt = ONE;
          w_head_nxt  = r_skid;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  // Registered from the next state so upstream never sees a combinational
  // path from out_ready. Low during reset, high one edge after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt != TWO);
    end
  end

  // HOLD pushes replay this value, so only non-HOLD pushes refresh it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold <= '0;
    end else if (w_push && (w_mode != HOLD)) begin
      r_hold <= w_word;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_pop) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_err <= 1'b0;
    end else if (w_push && w_oor) begin
      r_sel_err <= 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_head;
  assign out_par   = par_of(PAR_MAX_W'(r_head));
  assign out_count = r_count;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_sel_bank_pipe.sv
module tb_sel_bank_pipe;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: WIDTH=8, LANES=4, CNT_W=8
  logic        a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data;
  logic [1:0]  a_in_sel, a_in_mode;
  logic [7:0]  a_out_data, a_out_count;
  logic        a_out_par, a_sel_err;

  // Instance B: WIDTH=8, LANES=3, CNT_W=4
  logic        b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [23:0] b_in_data;
  logic [1:0]  b_in_sel, b_in_mode;
  logic [7:0]  b_out_data;
  logic [3:0]  b_out_count;
  logic        b_out_par, b_sel_err;

  int total = 0;
  int bad   = 0;

  sel_bank_pipe #(.WIDTH(8), .LANES(4), .CNT_W(8)) u_a (
    .clock(clock), .reset_n(a_rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_sel(a_in_sel), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_par(a_out_par),
    .out_count(a_out_count), .sel_err(a_sel_err)
  );

  sel_bank_pipe #(.WIDTH(8), .LANES(3), .CNT_W(4)) u_b (
    .clock(clock), .reset_n(b_rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_par(b_out_par),
    .out_count(b_out_count), .sel_err(b_sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_in_sel = '0;
    a_in_mode = 2'd0; a_out_ready = 1'b1;
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0;
    b_in_mode = 2'd0; b_out_ready = 1'b1;

    #2;
    chk("rst_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_data",  {24'd0, a_out_data},  32'd0);
    chk("rst_par",   {31'd0, a_out_par},   32'd0);
    chk("rst_count", {24'd0, a_out_count}, 32'd0);
    chk("rst_selerr",{31'd0, a_sel_err},   32'd0);

    step(); step();
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    step();
    chk("rdy_after_rel", {31'd0, a_in_ready}, 32'd1);

    // PASS, lane 2
    a_in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    a_in_sel = 2'd2; a_in_mode = 2'd0; a_in_valid = 1'b1;
    step();
    chk("pass_valid", {31'd0, a_out_valid}, 32'd1);
    chk("pass_data",  {24'd0, a_out_data},  32'h33);
    chk("pass_par",   {31'd0, a_out_par},   32'd0);
    chk("pass_cnt0",  {24'd0, a_out_count}, 32'd0);
    a_in_valid = 1'b0;
    step();
    chk("pass_cnt1",  {24'd0, a_out_count}, 32'd1);
    chk("pass_empty", {31'd0, a_out_valid}, 32'd0);

    // INVERT lane 0, then PARITY lanes 1 and 3
    a_in_sel = 2'd0; a_in_mode = 2'd1; a_in_valid = 1'b1;
    step();
    chk("inv_data", {24'd0, a_out_data}, 32'hEE);
    chk("inv_par",  {31'd0, a_out_par},  32'd0);
    a_in_sel = 2'd1; a_in_mode = 2'd2;
    step();
    chk("par22_data", {24'd0, a_out_data},  32'h00);
    chk("par22_cnt",  {24'd0, a_out_count}, 32'd2);
    a_in_data = {8'h07, 8'h33, 8'h22, 8'h11};
    a_in_sel = 2'd3;
    step();
    chk("par07_data", {24'd0, a_out_data},  32'h01);
    chk("par07_par",  {31'd0, a_out_par},   32'd1);
    chk("par07_cnt",  {24'd0, a_out_count}, 32'd3);
    a_in_valid = 1'b0;
    step();
    chk("drain1_cnt", {24'd0, a_out_count}, 32'd4);

    // Backpressure: third word refused until a slot frees
    a_out_ready = 1'b0;
    a_in_data = {8'h07, 8'h33, 8'h22, 8'hA1};
    a_in_sel = 2'd0; a_in_mode = 2'd0; a_in_valid = 1'b1;
    step();
    chk("bp1_rdy",  {31'd0, a_in_ready}, 32'd1);
    chk("bp1_data", {24'd0, a_out_data}, 32'hA1);
    a_in_data[7:0] = 8'hA2;
    step();
    chk("bp2_rdy",  {31'd0, a_in_ready}, 32'd0);
    chk("bp2_data", {24'd0, a_out_data}, 32'hA1);
    a_in_data[7:0] = 8'hA3;
    step();
    chk("bp3_rdy",  {31'd0, a_in_ready},  32'd0);
    chk("bp3_data", {24'd0, a_out_data},  32'hA1);
    chk("bp3_cnt",  {24'd0, a_out_count}, 32'd4);
    a_out_ready = 1'b1;
    step();
    chk("bp4_data", {24'd0, a_out_data},  32'hA2);
    chk("bp4_cnt",  {24'd0, a_out_count}, 32'd5);
    chk("bp4_rdy",  {31'd0, a_in_ready},  32'd1);
    step();
    chk("bp5_data", {24'd0, a_out_data},  32'hA3);
    chk("bp5_cnt",  {24'd0, a_out_count}, 32'd6);
    a_in_valid = 1'b0;
    step();
    chk("bp6_valid", {31'd0, a_out_valid}, 32'd0);
    chk("bp6_cnt",   {24'd0, a_out_count}, 32'd7);

    // HOLD replays the last non-HOLD push
    a_in_data[7:0] = 8'h5A; a_in_mode = 2'd0; a_in_valid = 1'b1;
    step();
    chk("hold0_data", {24'd0, a_out_data}, 32'h5A);
    a_in_data[7:0] = 8'h00; a_in_mode = 2'd3;
    step();
    chk("hold1_data", {24'd0, a_out_data},  32'h5A);
    chk("hold1_cnt",  {24'd0, a_out_count}, 32'd8);
    step();
    chk("hold2_data", {24'd0, a_out_data},  32'h5A);
    a_in_valid = 1'b0;
    step();
    chk("hold_cnt",   {24'd0, a_out_count}, 32'd10);

    // Select error on the 3-lane instance
    b_in_data = {8'h33, 8'h22, 8'h11};
    b_in_sel = 2'd3; b_in_mode = 2'd0; b_in_valid = 1'b1;
    step();
    chk("se_valid", {31'd0, b_out_valid}, 32'd1);
    chk("se_data",  {24'd0, b_out_data},  32'h00);
    chk("se_flag",  {31'd0, b_sel_err},   32'd1);
    b_in_sel = 2'd1;
    step();
    chk("se_next_data", {24'd0, b_out_data}, 32'h22);
    chk("se_sticky1",   {31'd0, b_sel_err},  32'd1);
    b_in_valid = 1'b0;
    step();
    chk("se_sticky2", {31'd0, b_sel_err},   32'd1);
    chk("se_cnt",     {28'd0, b_out_count}, 32'd2);
    #3; b_rst_n = 1'b0; #1;
    chk("se_cleared", {31'd0, b_sel_err},   32'd0);
    chk("se_rst_cnt", {28'd0, b_out_count}, 32'd0);
    #2; b_rst_n = 1'b1;
    step();
    chk("b_rdy_rel", {31'd0, b_in_ready}, 32'd1);

    // Counter wrap: 17 pops on a 4-bit counter
    b_in_sel = 2'd0; b_in_valid = 1'b1; b_out_ready = 1'b1;
    for (int i = 0; i < 17; i++) step();
    chk("wrap16_cnt", {28'd0, b_out_count}, 32'd0);
    b_in_valid = 1'b0;
    step();
    chk("wrap17_cnt",   {28'd0, b_out_count}, 32'd1);
    chk("wrap17_valid", {31'd0, b_out_valid}, 32'd0);

    // Fill to TWO, then async reset between edges
    b_out_ready = 1'b0; b_in_valid = 1'b1;
    step(); step();
    b_in_valid = 1'b0;
    chk("two_valid", {31'd0, b_out_valid}, 32'd1);
    chk("two_rdy",   {31'd0, b_in_ready},  32'd0);
    chk("two_data",  {24'd0, b_out_data},  32'h11);
    chk("two_par",   {31'd0, b_out_par},   32'd0);
    #3; b_rst_n = 1'b0; #1;
    chk("arst_valid", {31'd0, b_out_valid}, 32'd0);
    chk("arst_cnt",   {28'd0, b_out_count}, 32'd0);
    chk("arst_data",  {24'd0, b_out_data},  32'd0);
    #2; b_rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
